// File: rtl/yonga_can_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// yonga_can_tx_scheduler_if
// Bundle of mailbox-side and controller-side signals for the CAN TX scheduler.
//   i_mb_req        [3:0]      per-mailbox transmit request pulse
//   i_mb_ids        [4*ID_W-1:0] packed mailbox IDs, mailbox k at [k*ID_W +: ID_W]
//   i_config_enable            controller being configured, blocks new starts
//   i_done_tx                  controller frame-complete indication
//   i_sts_code      [2:0]      controller status (3'h2 = arbitration lost / bit error)
//   o_send                     one-cycle start pulse to the controller
//   o_sel           [1:0]      mailbox index driving the packetizer
//   o_busy                     transmission in progress
//   o_mb_pending    [3:0]      sticky pending flags
//   o_mb_done       [3:0]      one-cycle success pulse per mailbox
//   o_mb_abort      [3:0]      one-cycle drop pulse per mailbox
//   o_ctrl_abort               one-cycle pulse for the controller reset
// Modports: slave = scheduler side, master = driver/integrator side.
// ---------------------------------------------------------------------------
interface yonga_can_tx_scheduler_if #(
    parameter int ID_W = 11
);
    logic [3:0]        i_mb_req;
    logic [4*ID_W-1:0] i_mb_ids;
    logic              i_config_enable;
    logic              i_done_tx;
    logic [2:0]        i_sts_code;
    logic              o_send;
    logic [1:0]        o_sel;
    logic              o_busy;
    logic [3:0]        o_mb_pending;
    logic [3:0]        o_mb_done;
    logic [3:0]        o_mb_abort;
    logic              o_ctrl_abort;

    modport slave (
        input  i_mb_req, i_mb_ids, i_config_enable, i_done_tx, i_sts_code,
        output o_send, o_sel, o_busy, o_mb_pending, o_mb_done, o_mb_abort, o_ctrl_abort
    );

    modport master (
        output i_mb_req, i_mb_ids, i_config_enable, i_done_tx, i_sts_code,
        input  o_send, o_sel, o_busy, o_mb_pending, o_mb_done, o_mb_abort, o_ctrl_abort
    );
endinterface

// File: rtl/yonga_can_tx_scheduler.sv
// ---------------------------------------------------------------------------
// yonga_can_tx_scheduler
// Four-mailbox CAN transmit scheduler. Pending requests are served one at a
// time, lowest identifier first (lowest mailbox index on a tie). Each frame
// is started with a one-cycle send pulse and retired either on the
// controller's done indication (success) or on a timeout / retry limit
// (abort, which also pulses o_ctrl_abort).
//
// Ports:
//   i_sched_clk  single clock, rising edge
//   i_sched_rst  synchronous active-high reset
//   bus          yonga_can_tx_scheduler_if.slave (mailbox and controller signals)
// Parameters:
//   ID_W         identifier width
//   TIMEOUT_CYC  WAIT cycles before a forced abort (16-bit counter)
// Optional feature:
//   YONGA_CAN_SCHED_RETRY_LIMIT_EN  when defined, the fourth arbitration-lost /
//   bit-error event during WAIT aborts the frame. When undefined the events are
//   still counted but only the timeout aborts.
// ---------------------------------------------------------------------------
module yonga_can_tx_scheduler #(
    parameter int ID_W        = 11,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          i_sched_clk,
    input  logic                          i_sched_rst,
    yonga_can_tx_scheduler_if.slave       bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SEND   = 3'd2,
        WAIT   = 3'd3,
        RETIRE = 3'd4
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  lost_q, lost_d;
    logic [15:0] to_q, to_d;
    logic        abort_q, abort_d;
    logic        sts_err_prev_q;

    logic [ID_W-1:0] mb_id [4];
    logic [3:0]      sel_onehot;
    logic [1:0]      win_idx;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic            sts_err_rise;
    logic [2:0]      lost_step;
    logic [15:0]     to_step;
    logic            retry_hit;
    logic            in_flight;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mb
            assign mb_id[gi]      = bus.i_mb_ids[gi*ID_W +: ID_W];
            assign sel_onehot[gi] = (sel_q == 2'(gi));
        end
    endgenerate

    // Strict less-than while scanning upward keeps the lowest index on a tie.
    always_comb begin
        win_idx   = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (pending_q[k] && (!win_found || (mb_id[k] < win_id))) begin
                win_found = 1'b1;
                win_idx   = 2'(k);
                win_id    = mb_id[k];
            end
        end
    end

    assign in_flight    = (state_q == SEND) || (state_q == WAIT);
    assign sts_err_rise = (bus.i_sts_code == 3'h2) && !sts_err_prev_q;
    assign lost_step    = (sts_err_rise && (lost_q != 3'd7)) ? lost_q + 3'd1 : lost_q;
    assign to_step      = to_q + 16'd1;

`ifdef YONGA_CAN_SCHED_RETRY_LIMIT_EN
    assign retry_hit = (lost_step >= 3'd4);
`else
    assign retry_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lost_d  = lost_q;
        to_d    = to_q;
        abort_d = abort_q;
        // Requests for the in-flight mailbox are dropped; a request arriving
        // while its mailbox retires wins over the clear so it is not lost.
        pending_d = (pending_q & ~((state_q == RETIRE) ? sel_onehot : 4'b0))
                  | (bus.i_mb_req & ~(in_flight ? sel_onehot : 4'b0));
        case (state_q)
            IDLE: begin
                if ((|pending_q) && !bus.i_config_enable) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                sel_d   = win_idx;
                lost_d  = '0;
                to_d    = '0;
                abort_d = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                lost_d = lost_step;
                to_d   = to_step;
                // Completion takes precedence over a coincident abort cause.
                if (bus.i_done_tx) begin
                    abort_d = 1'b0;
                    state_d = RETIRE;
                end else if ((to_step == TO_LIMIT) || retry_hit) begin
                    abort_d = 1'b1;
                    state_d = RETIRE;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sched_clk) begin
        if (i_sched_rst) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            sel_q          <= '0;
            lost_q         <= '0;
            to_q           <= '0;
            abort_q        <= 1'b0;
            sts_err_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            sel_q          <= sel_d;
            lost_q         <= lost_d;
            to_q           <= to_d;
            abort_q        <= abort_d;
            sts_err_prev_q <= (bus.i_sts_code == 3'h2);
        end
    end

    assign bus.o_send       = (state_q == SEND);
    assign bus.o_busy       = in_flight;
    assign bus.o_sel        = sel_q;
    assign bus.o_mb_pending = pending_q;
    assign bus.o_mb_done    = ((state_q == RETIRE) && !abort_q) ? sel_onehot : 4'b0;
    assign bus.o_mb_abort   = ((state_q == RETIRE) &&  abort_q) ? sel_onehot : 4'b0;
    assign bus.o_ctrl_abort = (state_q == RETIRE) && abort_q;
endmodule
